bldc_regbank_arbiter: RTL

//  Owns the BLDC register bank (I2C indices 0x40..0x53) and arbitrates access between the I2C slave and the BLDC core.
//  - I2C side is driven by the slave's level-style write/read strobes.
//  - Core side is a req/gnt port used to update status registers.
//  - Exports the whole bank as a flat config bus, plus a commit pulse for each I2C write.

---
 rtl/bldc_regbank_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/bldc_regbank_arbiter.sv
// rtl/bldc_regbank_arbiter.sv - BLDC register bank shared by the I2C slave and the BLDC core
module bldc_regbank_arbiter #(
  parameter logic [7:0]          BASE_IDX = 8'h40,
  parameter int                  NUM_REGS = 20,
  parameter logic [NUM_REGS-1:0] RO_MASK  = 20'hF0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i2c_wr,
  input  logic                  i2c_rd,
  input  logic [7:0]            i2c_index,
  input  logic [7:0]            i2c_wdata,
  output logic [7:0]            i2c_rdata,
  output logic                  i2c_err,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [4:0]            core_addr,
  input  logic [7:0]            core_wdata,
  output logic [7:0]            core_rdata,
  output logic                  core_gnt,
  output logic [NUM_REGS*8-1:0] cfg_bus,
  output logic                  cfg_update,
  output logic [4:0]            cfg_upd_idx
);

  localparam logic [7:0] NUM_REGS8 = 8'(NUM_REGS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SRV_I2C  = 2'd1,
    SRV_CORE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic [7:0]  regs [NUM_REGS];
  logic        wr_q;
  logic        rd_q;
  logic        wr_pend;
  logic        rd_pend;
  logic [7:0]  wr_idx;
  logic [7:0]  wr_data;
  logic [7:0]  rd_idx;
  logic        rr_last_core;

  logic        wr_edge;
  logic        rd_edge;
  logic [7:0]  wr_rel;
  logic [7:0]  rd_rel;
  logic        wr_ok;
  logic        rd_ok;
  logic        core_ok;
  logic        srv_wr;
  logic        srv_rd;

  assign wr_edge = i2c_wr & ~wr_q;
  assign rd_edge = i2c_rd & ~rd_q;

  // Underflow of the subtraction wraps high and fails the range check.
  assign wr_rel  = wr_idx - BASE_IDX;
  assign rd_rel  = rd_idx - BASE_IDX;
  assign wr_ok   = (wr_rel < NUM_REGS8) && !RO_MASK[wr_rel[4:0]];
  assign rd_ok   = (rd_rel < NUM_REGS8);
  assign core_ok = ({3'b000, core_addr} < NUM_REGS8);

  // A pending write always goes before a pending read on the same I2C grant.
  assign srv_wr  = (state == SRV_I2C) && wr_pend;
  assign srv_rd  = (state == SRV_I2C) && !wr_pend && rd_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    core_gnt   = 1'b0;
    core_rdata = 8'h00;
    case (state)
      IDLE: begin
        if ((wr_pend || rd_pend) && (!core_req || rr_last_core)) begin
          state_nx = SRV_I2C;
        end else if (core_req) begin
          state_nx = SRV_CORE;
        end
      end
      SRV_I2C: begin
        state_nx = IDLE;
      end
      SRV_CORE: begin
        state_nx = IDLE;
        core_gnt = !rst;
        if (core_ok && !rst) begin
          core_rdata = regs[core_addr];
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= 8'h00;
      end
      wr_q         <= 1'b0;
      rd_q         <= 1'b0;
      wr_pend      <= 1'b0;
      rd_pend      <= 1'b0;
      wr_idx       <= 8'h00;
      wr_data      <= 8'h00;
      rd_idx       <= 8'h00;
      rr_last_core <= 1'b1;
      i2c_rdata    <= 8'hFF;
      i2c_err      <= 1'b0;
      cfg_update   <= 1'b0;
      cfg_upd_idx  <= 5'd0;
    end else begin
      wr_q       <= i2c_wr;
      rd_q       <= i2c_rd;
      i2c_err    <= 1'b0;
      cfg_update <= 1'b0;

      if (srv_wr) begin
        wr_pend <= 1'b0;
        if (wr_ok) begin
          regs[wr_rel[4:0]] <= wr_data;
          cfg_update        <= 1'b1;
          cfg_upd_idx       <= wr_rel[4:0];
        end else begin
          i2c_err <= 1'b1;
        end
      end

      if (srv_rd) begin
        rd_pend <= 1'b0;
        if (rd_ok) begin
          i2c_rdata <= regs[rd_rel[4:0]];
        end else begin
          i2c_rdata <= 8'hFF;
          i2c_err   <= 1'b1;
        end
      end

      // A fresh edge in the service cycle re-arms the flag it just cleared.
      if (wr_edge) begin
        wr_pend <= 1'b1;
        wr_idx  <= i2c_index;
        wr_data <= i2c_wdata;
      end
      if (rd_edge) begin
        rd_pend <= 1'b1;
        rd_idx  <= i2c_index;
      end

      if (state == SRV_I2C) begin
        rr_last_core <= 1'b0;
      end
      if (state == SRV_CORE) begin
        rr_last_core <= 1'b1;
        if (core_we && core_ok) begin
          regs[core_addr] <= core_wdata;
        end
      end
    end
  end

  always_comb begin
    cfg_bus = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cfg_bus[8*i +: 8] = regs[i];
    end
  end

endmodule
